exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception/ERET sequencer sitting between the memory stage and the CP0 register file. Each cycle it examines the instruction committing in M, picks the highest-priority exception (or an interrupt, or an ERET), drives the CP0 exception/ERET strobes for exactly one cycle, and tracks branch-delay-slot status. It then flushes the pipeline and holds a redirect request to fetch until fetch accepts it.

## Interface

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception and interrupt

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- m_valid  in  1  M-stage slot holds a real instruction
- m_stall  in  1  M stage held this cycle; the instruction does not commit
- m_pc  in  32  PC of the M instruction
- m_vaddr  in  32  data address of the M load/store
- m_is_branch  in  1  M instruction is a branch/jump, so its successor is a delay slot
- m_eret  in  1  M instruction is ERET
- exc_fetch_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_data_adel, exc_data_ades  in  1 each  exception flags carried with the M instruction
- interrupt  in  1  pending, enabled interrupt from CP0
- cp0_epc  in  32  current EPC from CP0
- exception  out  1  CP0 exception strobe
- exc_code  out  6  CP0 ExcCode; bit 5 is always 0
- is_bad_addr  out  1  BadVAddr write enable
- bad_addr  out  32  BadVAddr value
- exc_pc  out  32  faulting PC, passed raw (CP0 applies the -4 for delay slots)
- in_delay_slot  out  1  CP0 BD input
- eret  out  1  CP0 ERET strobe (clears EXL)
- flush  out  1  kill all instructions in F/D/E/M
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts the redirect this cycle

## Operation

- Commit event: m_valid & ~m_stall & state==IDLE.
- Trigger: a commit event with any exception flag set, interrupt set, or m_eret set.
- Priority, highest first:
  - interrupt: code 0
  - exc_fetch_adel: 4
  - exc_ri: 10
  - exc_ov: 12
  - exc_sys: 8
  - exc_bp: 9
  - exc_data_adel: 4
  - exc_data_ades: 5
- Any exception or interrupt beats m_eret in the same cycle. In that case the ERET is not executed.
- Exception cycle outputs:
  - exception=1, exc_code per the priority list, exc_pc=m_pc, in_delay_slot=ds_flag.
  - is_bad_addr=1 only for AdEL/AdES.
  - bad_addr=m_pc for a fetch AdEL; m_vaddr for a data AdEL/AdES; 0 otherwise.
- ERET cycle: eret=1 and exception=0.
- Target latch: on a trigger, redirect_pc is registered as EXC_VECTOR for an exception or cp0_epc (sampled that cycle) for an ERET.
- ds_flag register:
  - On every non-trigger commit event, ds_flag <= m_is_branch.
  - On a trigger, ds_flag <= 0.
  - Unchanged otherwise.
- FSM, two states:
  - IDLE: flush=0, redirect_valid=0. On a trigger, flush=1 combinationally in the same cycle, then go to REDIRECT.
  - REDIRECT: flush=1, redirect_valid=1, all CP0 strobes forced to 0, M inputs ignored. If redirect_ready=1, return to IDLE at the next edge.
- exception and eret are combinational and qualified by the commit event, so they are high for at most one cycle per trigger. A stalled M instruction never strobes.

## Timing

- Reset (resetn=0 at an edge): state=IDLE, ds_flag=0, redirect_pc=0. A reset during REDIRECT abandons the redirect.
- Reset values of all outputs: every strobe and redirect_valid is 0 during and after reset until a trigger.
- Latency, trigger at cycle T:
  - T: CP0 strobe and flush.
  - CP0 state updates at edge T+1.
  - redirect_valid is high from T+1.
  - If redirect_ready is high at T+k, state is IDLE at T+k+1. The minimum window is 1 cycle (ready at T+1).
- The redirect handshake is a level hold: redirect_pc is stable while redirect_valid=1. Fetch must not see a new target before acceptance.
- A trigger with m_stall=1 is deferred until the stall clears. Flags must be held by the pipeline.
- m_valid=0 blocks interrupts: they are taken only on a valid committing instruction.

## Test plan

- Ov on a non-delay-slot add: m_pc=0x8000_1000, exc_ov=1, redirect_ready=1 at T+2 -> at T exception=1, exc_code=12, exc_pc=0x8000_1000, in_delay_slot=0, is_bad_addr=0, flush=1; redirect_valid at T+1..T+2, redirect_pc=0xBFC0_0380; IDLE at T+3.
- Delay slot: commit a branch at 0x8000_0100, then AdES at 0x8000_0104 with m_vaddr=0x1234_5679 -> exc_code=5, in_delay_slot=1, is_bad_addr=1, bad_addr=0x1234_5679.
- Priority: interrupt, exc_fetch_adel and m_eret all set on one commit -> exc_code=0, eret=0, redirect_pc=EXC_VECTOR. Repeat with interrupt=0 -> exc_code=4, bad_addr=m_pc.
- ERET: cp0_epc=0x8000_2000, m_eret=1 -> eret=1 for one cycle, exception=0, redirect_pc=0x8000_2000. Hold redirect_ready=0 for 5 cycles -> redirect_valid and flush stay 1 for all 5, and a new exc_sys presented meanwhile produces no strobe.
- Stall: exc_sys=1 with m_stall=1 for 3 cycles, then 0 -> exception is low for the 3 stalled cycles, then exactly one pulse with exc_code=8.
- Reset mid-REDIRECT: resetn=0 during REDIRECT -> the next cycle shows redirect_valid=0, flush=0, and ds_flag cleared (a following exception reports in_delay_slot=0).

Source files
------------

// File: rtl/exc_ctrl_if.sv
// M-stage / CP0 / fetch-redirect bundle for the exception sequencer.
// master = pipeline side driving M-stage state, slave = exc_ctrl.
interface exc_ctrl_if;
  logic        m_valid;
  logic        m_stall;
  logic [31:0] m_pc;
  logic [31:0] m_vaddr;
  logic        m_is_branch;
  logic        m_eret;
  logic        exc_fetch_adel;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_data_adel;
  logic        exc_data_ades;
  logic        interrupt;
  logic [31:0] cp0_epc;
  logic        exception;
  logic [5:0]  exc_code;
  logic        is_bad_addr;
  logic [31:0] bad_addr;
  logic [31:0] exc_pc;
  logic        in_delay_slot;
  logic        eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output m_valid, m_stall, m_pc, m_vaddr, m_is_branch, m_eret,
           exc_fetch_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_data_adel, exc_data_ades,
           interrupt, cp0_epc, redirect_ready,
    input  exception, exc_code, is_bad_addr, bad_addr, exc_pc, in_delay_slot,
           eret, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  m_valid, m_stall, m_pc, m_vaddr, m_is_branch, m_eret,
           exc_fetch_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_data_adel, exc_data_ades,
           interrupt, cp0_epc, redirect_ready,
    output exception, exc_code, is_bad_addr, bad_addr, exc_pc, in_delay_slot,
           eret, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: prioritises M-stage exceptions, strobes CP0 for one
// cycle, flushes the pipe and holds a redirect to fetch until it is accepted.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic      clk,
  input  logic      resetn,
  exc_ctrl_if.slave bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        ds_flag_q, ds_flag_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        commit, any_exc, exc_stb, eret_stb, trig;
  logic [5:0]  code;
  logic        bad_v;
  logic [31:0] bad_a;

  // Qualifying by resetn keeps every strobe quiet while reset is held.
  always_comb begin
    commit  = resetn & bus.m_valid & ~bus.m_stall & (state_q == ST_IDLE);
    any_exc = bus.interrupt | bus.exc_fetch_adel | bus.exc_ri | bus.exc_ov |
              bus.exc_sys | bus.exc_bp | bus.exc_data_adel | bus.exc_data_ades;
    exc_stb  = commit & any_exc;
    eret_stb = commit & bus.m_eret & ~any_exc;
    trig     = exc_stb | eret_stb;
  end

  always_comb begin
    code  = 6'd0;
    bad_v = 1'b0;
    bad_a = 32'd0;
    if (bus.interrupt) begin
      code = 6'd0;
    end else if (bus.exc_fetch_adel) begin
      code  = 6'd4;
      bad_v = 1'b1;
      bad_a = bus.m_pc;
    end else if (bus.exc_ri) begin
      code = 6'd10;
    end else if (bus.exc_ov) begin
      code = 6'd12;
    end else if (bus.exc_sys) begin
      code = 6'd8;
    end else if (bus.exc_bp) begin
      code = 6'd9;
    end else if (bus.exc_data_adel) begin
      code  = 6'd4;
      bad_v = 1'b1;
      bad_a = bus.m_vaddr;
    end else if (bus.exc_data_ades) begin
      code  = 6'd5;
      bad_v = 1'b1;
      bad_a = bus.m_vaddr;
    end
  end

  // CP0-facing data is zeroed outside the strobe cycle.
  always_comb begin
    bus.exception      = exc_stb;
    bus.exc_code       = exc_stb ? code : 6'd0;
    bus.is_bad_addr    = exc_stb & bad_v;
    bus.bad_addr       = exc_stb ? bad_a : 32'd0;
    bus.exc_pc         = exc_stb ? bus.m_pc : 32'd0;
    bus.in_delay_slot  = exc_stb & ds_flag_q;
    bus.eret           = eret_stb;
    bus.flush          = (state_q == ST_REDIR) | trig;
    bus.redirect_valid = (state_q == ST_REDIR);
    bus.redirect_pc    = redirect_pc_q;
  end

  always_comb begin
    state_d       = state_q;
    ds_flag_d     = ds_flag_q;
    redirect_pc_d = redirect_pc_q;
    if (state_q == ST_REDIR) begin
      if (bus.redirect_ready) state_d = ST_IDLE;
    end else if (trig) begin
      state_d       = ST_REDIR;
      ds_flag_d     = 1'b0;
      redirect_pc_d = exc_stb ? EXC_VECTOR : bus.cp0_epc;
    end else if (commit) begin
      ds_flag_d = bus.m_is_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      ds_flag_q     <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      ds_flag_q     <= ds_flag_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: table vectors, hand sequences for the
// multi-cycle cases, and random traffic against a behavioural model.
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [6:0] F_FADEL = 7'b0000001, F_RI = 7'b0000010, F_OV = 7'b0000100,
                         F_SYS = 7'b0001000, F_BP = 7'b0010000, F_DADEL = 7'b0100000,
                         F_DADES = 7'b1000000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  exc_ctrl_if bus();
  exc_ctrl #(.EXC_VECTOR(VEC)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic        rstn, valid, stall, br, eret, intr, ready;
    logic [6:0]  flg;
    logic [31:0] pc, vaddr, epc;
  } in_t;

  typedef struct {
    in_t         i;
    logic        x_exc;
    logic [5:0]  x_code;
    logic        x_eret;
    logic        x_bad;
    logic [31:0] x_badaddr;
    logic [31:0] x_rpc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model: pending-redirect flag, delay-slot flag, latched target
  bit          m_busy = 1'b0;
  bit          m_bd   = 1'b0;
  logic [31:0] m_tgt  = 32'd0;
  bit          t_commit, t_exc, t_eret;
  in_t         cur;
  int          pri_code [8] = '{0, 4, 10, 12, 8, 9, 4, 5};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mkin(input logic [6:0] flg, input logic intr, input logic eret,
                               input logic [31:0] pc, input logic [31:0] vaddr,
                               input logic [31:0] epc);
    in_t v;
    v.rstn = 1'b1; v.valid = 1'b1; v.stall = 1'b0; v.br = 1'b0; v.ready = 1'b1;
    v.flg = flg; v.intr = intr; v.eret = eret; v.pc = pc; v.vaddr = vaddr; v.epc = epc;
    return v;
  endfunction

  function automatic in_t idle_in(input logic ready);
    in_t v;
    v = mkin(7'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    v.valid = 1'b0;
    v.ready = ready;
    return v;
  endfunction

  // Apply inputs, let them settle, and compare every output with the model.
  task automatic drive(input in_t v);
    logic [7:0]  req;
    int          idx;
    logic        e_bad;
    logic [31:0] e_badaddr;
    cur = v;
    resetn             = v.rstn;
    bus.m_valid        = v.valid;
    bus.m_stall        = v.stall;
    bus.m_pc           = v.pc;
    bus.m_vaddr        = v.vaddr;
    bus.m_is_branch    = v.br;
    bus.m_eret         = v.eret;
    bus.exc_fetch_adel = v.flg[0];
    bus.exc_ri         = v.flg[1];
    bus.exc_ov         = v.flg[2];
    bus.exc_sys        = v.flg[3];
    bus.exc_bp         = v.flg[4];
    bus.exc_data_adel  = v.flg[5];
    bus.exc_data_ades  = v.flg[6];
    bus.interrupt      = v.intr;
    bus.cp0_epc        = v.epc;
    bus.redirect_ready = v.ready;
    #1;
    req = {v.flg, v.intr};
    idx = -1;
    for (int k = 0; k < 8; k++) if (req[k] && idx < 0) idx = k;
    t_commit = v.rstn && v.valid && !v.stall && !m_busy;
    t_exc    = t_commit && (idx >= 0);
    t_eret   = t_commit && v.eret && (idx < 0);
    e_bad     = t_exc && (idx == 1 || idx == 6 || idx == 7);
    e_badaddr = !e_bad ? 32'd0 : (idx == 1 ? v.pc : v.vaddr);
    chk("exception", {31'd0, bus.exception}, {31'd0, t_exc});
    chk("exc_code", {26'd0, bus.exc_code}, t_exc ? pri_code[idx] : 0);
    chk("eret", {31'd0, bus.eret}, {31'd0, t_eret});
    chk("is_bad_addr", {31'd0, bus.is_bad_addr}, {31'd0, e_bad});
    chk("bad_addr", bus.bad_addr, e_badaddr);
    chk("exc_pc", bus.exc_pc, t_exc ? v.pc : 32'd0);
    chk("in_delay_slot", {31'd0, bus.in_delay_slot}, {31'd0, t_exc && m_bd});
    chk("flush", {31'd0, bus.flush}, {31'd0, m_busy || t_exc || t_eret});
    chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_busy});
    chk("redirect_pc", bus.redirect_pc, m_tgt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cur.rstn) begin
      m_busy = 1'b0; m_bd = 1'b0; m_tgt = 32'd0;
    end else if (m_busy) begin
      if (cur.ready) m_busy = 1'b0;
    end else if (t_exc || t_eret) begin
      m_busy = 1'b1;
      m_bd   = 1'b0;
      m_tgt  = t_exc ? VEC : cur.epc;
    end else if (t_commit) begin
      m_bd = cur.br;
    end
    #1;
  endtask

  vec_t tbl [13];
  in_t  v;

  initial begin
    tbl[0]  = '{mkin(F_OV, 1'b0, 1'b0, 32'h8000_1000, 32'h0, 32'h0), 1'b1, 6'd12, 1'b0, 1'b0, 32'h0, VEC};
    tbl[1]  = '{mkin(F_RI, 1'b0, 1'b0, 32'h8000_1010, 32'h0, 32'h0), 1'b1, 6'd10, 1'b0, 1'b0, 32'h0, VEC};
    tbl[2]  = '{mkin(F_SYS, 1'b0, 1'b0, 32'h8000_1020, 32'h0, 32'h0), 1'b1, 6'd8, 1'b0, 1'b0, 32'h0, VEC};
    tbl[3]  = '{mkin(F_BP, 1'b0, 1'b0, 32'h8000_1030, 32'h0, 32'h0), 1'b1, 6'd9, 1'b0, 1'b0, 32'h0, VEC};
    tbl[4]  = '{mkin(F_DADEL, 1'b0, 1'b0, 32'h8000_1040, 32'h1000_0003, 32'h0), 1'b1, 6'd4, 1'b0, 1'b1, 32'h1000_0003, VEC};
    tbl[5]  = '{mkin(F_DADES, 1'b0, 1'b0, 32'h8000_1050, 32'h2000_0002, 32'h0), 1'b1, 6'd5, 1'b0, 1'b1, 32'h2000_0002, VEC};
    tbl[6]  = '{mkin(F_FADEL, 1'b0, 1'b0, 32'h8000_0201, 32'h5555_0000, 32'h0), 1'b1, 6'd4, 1'b0, 1'b1, 32'h8000_0201, VEC};
    tbl[7]  = '{mkin(7'h7F, 1'b1, 1'b1, 32'h8000_0301, 32'h0, 32'h8000_2000), 1'b1, 6'd0, 1'b0, 1'b0, 32'h0, VEC};
    tbl[8]  = '{mkin(F_FADEL | F_DADES, 1'b0, 1'b1, 32'h8000_0401, 32'h7, 32'h8000_2000), 1'b1, 6'd4, 1'b0, 1'b1, 32'h8000_0401, VEC};
    tbl[9]  = '{mkin(7'd0, 1'b0, 1'b1, 32'h8000_0500, 32'h0, 32'h8000_2000), 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 32'h8000_2000};
    tbl[10] = '{mkin(F_RI | F_SYS | F_BP, 1'b0, 1'b0, 32'h8000_0600, 32'h0, 32'h0), 1'b1, 6'd10, 1'b0, 1'b0, 32'h0, VEC};
    tbl[11] = '{mkin(7'd0, 1'b1, 1'b0, 32'h8000_0700, 32'h0, 32'h0), 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, VEC};
    tbl[11].i.valid = 1'b0;
    tbl[12] = '{mkin(F_OV, 1'b0, 1'b1, 32'h8000_0800, 32'h0, 32'h8000_3000), 1'b1, 6'd12, 1'b0, 1'b0, 32'h0, VEC};

    // reset, with an excepting instruction presented to prove strobes stay low
    v = mkin(F_OV, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
    v.rstn = 1'b0;
    cur = v;
    resetn = 1'b0;
    @(posedge clk); #1;
    drive(v);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_exception", {31'd0, bus.exception}, 32'd0);
    tick();
    drive(idle_in(1'b1));
    chk("post_rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    tick();

    // table: each row is one commit from IDLE followed by a drain cycle
    foreach (tbl[r]) begin
      drive(tbl[r].i);
      chk($sformatf("tbl%0d_exception", r), {31'd0, bus.exception}, {31'd0, tbl[r].x_exc});
      chk($sformatf("tbl%0d_code", r), {26'd0, bus.exc_code}, {26'd0, tbl[r].x_code});
      chk($sformatf("tbl%0d_eret", r), {31'd0, bus.eret}, {31'd0, tbl[r].x_eret});
      chk($sformatf("tbl%0d_bad", r), {31'd0, bus.is_bad_addr}, {31'd0, tbl[r].x_bad});
      chk($sformatf("tbl%0d_badaddr", r), bus.bad_addr, tbl[r].x_badaddr);
      tick();
      drive(idle_in(1'b1));
      chk($sformatf("tbl%0d_rv", r), {31'd0, bus.redirect_valid}, {31'd0, tbl[r].x_exc | tbl[r].x_eret});
      chk($sformatf("tbl%0d_rpc", r), bus.redirect_pc, tbl[r].x_rpc);
      tick();
    end

    // Ov with a two-cycle redirect window
    v = mkin(F_OV, 1'b0, 1'b0, 32'h8000_1000, 32'h0, 32'h0);
    v.ready = 1'b0;
    drive(v);
    chk("ov_exception", {31'd0, bus.exception}, 32'd1);
    chk("ov_code", {26'd0, bus.exc_code}, 32'd12);
    chk("ov_exc_pc", bus.exc_pc, 32'h8000_1000);
    chk("ov_bd", {31'd0, bus.in_delay_slot}, 32'd0);
    chk("ov_flush", {31'd0, bus.flush}, 32'd1);
    tick();
    drive(idle_in(1'b0));
    chk("ov_rv_t1", {31'd0, bus.redirect_valid}, 32'd1);
    chk("ov_rpc_t1", bus.redirect_pc, VEC);
    tick();
    drive(idle_in(1'b1));
    chk("ov_rv_t2", {31'd0, bus.redirect_valid}, 32'd1);
    tick();
    drive(idle_in(1'b1));
    chk("ov_rv_t3", {31'd0, bus.redirect_valid}, 32'd0);
    chk("ov_flush_t3", {31'd0, bus.flush}, 32'd0);
    tick();

    // delay slot: branch then AdES in its slot
    v = mkin(7'd0, 1'b0, 1'b0, 32'h8000_0100, 32'h0, 32'h0);
    v.br = 1'b1;
    drive(v); tick();
    drive(mkin(F_DADES, 1'b0, 1'b0, 32'h8000_0104, 32'h1234_5679, 32'h0));
    chk("ds_code", {26'd0, bus.exc_code}, 32'd5);
    chk("ds_bd", {31'd0, bus.in_delay_slot}, 32'd1);
    chk("ds_bad", {31'd0, bus.is_bad_addr}, 32'd1);
    chk("ds_badaddr", bus.bad_addr, 32'h1234_5679);
    tick();
    drive(idle_in(1'b1)); tick();

    // ERET with fetch holding off for five cycles
    v = mkin(7'd0, 1'b0, 1'b1, 32'h8000_0900, 32'h0, 32'h8000_2000);
    v.ready = 1'b0;
    drive(v);
    chk("eret_strobe", {31'd0, bus.eret}, 32'd1);
    chk("eret_exception", {31'd0, bus.exception}, 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      v = mkin(F_SYS, 1'b0, 1'b0, 32'h8000_0A00, 32'h0, 32'h8000_4000);
      v.ready = 1'b0;
      drive(v);
      chk("eret_hold_rv", {31'd0, bus.redirect_valid}, 32'd1);
      chk("eret_hold_flush", {31'd0, bus.flush}, 32'd1);
      chk("eret_hold_exc", {31'd0, bus.exception}, 32'd0);
      chk("eret_hold_rpc", bus.redirect_pc, 32'h8000_2000);
      tick();
    end
    drive(idle_in(1'b1)); tick();

    // stalled syscall is deferred, then strobes exactly once
    for (int c = 0; c < 3; c++) begin
      v = mkin(F_SYS, 1'b0, 1'b0, 32'h8000_0B00, 32'h0, 32'h0);
      v.stall = 1'b1;
      drive(v);
      chk("stall_exc", {31'd0, bus.exception}, 32'd0);
      tick();
    end
    drive(mkin(F_SYS, 1'b0, 1'b0, 32'h8000_0B00, 32'h0, 32'h0));
    chk("stall_release_exc", {31'd0, bus.exception}, 32'd1);
    chk("stall_release_code", {26'd0, bus.exc_code}, 32'd8);
    tick();
    drive(mkin(F_SYS, 1'b0, 1'b0, 32'h8000_0B00, 32'h0, 32'h0));
    chk("stall_single_pulse", {31'd0, bus.exception}, 32'd0);
    tick();
    drive(idle_in(1'b1)); tick();

    // reset during REDIRECT, and reset clearing a set delay-slot flag
    v = mkin(F_OV, 1'b0, 1'b0, 32'h8000_0C00, 32'h0, 32'h0);
    v.ready = 1'b0;
    drive(v); tick();
    v = idle_in(1'b0);
    v.rstn = 1'b0;
    drive(v); tick();
    drive(idle_in(1'b0));
    chk("rstmid_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rstmid_flush", {31'd0, bus.flush}, 32'd0);
    tick();
    v = mkin(7'd0, 1'b0, 1'b0, 32'h8000_0D00, 32'h0, 32'h0);
    v.br = 1'b1;
    drive(v); tick();
    v = idle_in(1'b0);
    v.rstn = 1'b0;
    drive(v); tick();
    drive(mkin(F_BP, 1'b0, 1'b0, 32'h8000_0D04, 32'h0, 32'h0));
    chk("rst_clears_bd", {31'd0, bus.in_delay_slot}, 32'd0);
    chk("rst_bd_exc", {31'd0, bus.exception}, 32'd1);
    tick();
    drive(idle_in(1'b1)); tick();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      v.rstn  = ($urandom_range(99) != 0);
      v.valid = ($urandom_range(3) != 0);
      v.stall = ($urandom_range(3) == 0);
      v.br    = ($urandom_range(2) == 0);
      v.eret  = ($urandom_range(15) == 0);
      v.intr  = ($urandom_range(15) == 0);
      v.ready = $urandom_range(1);
      for (int k = 0; k < 7; k++) v.flg[k] = ($urandom_range(11) == 0);
      v.pc    = $urandom;
      v.vaddr = $urandom;
      v.epc   = $urandom;
      drive(v);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
